// File: rtl/onchip_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// onchip_mem_arb_pkg
// Shared types and constants for the on-chip memory arbiter:
//   state_e    - access sequencer states (IDLE -> ISSUE -> RESP)
//   GNT_CPU/LDR - grant index encoding used by the arbiter and the top
//   mem_req_t  - one requester's payload (byte address, write data, strobes)
// -----------------------------------------------------------------------------
package onchip_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic GNT_CPU = 1'b0;
    localparam logic GNT_LDR = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_rr_arb2.sv
// -----------------------------------------------------------------------------
// mem_rr_arb2
// Two-way round-robin picker. A lone requester is always granted; when both
// request, the port that did not win the previous contest is granted.
// last_grant only moves on a real contest, so it records who won the most
// recent tie. It resets to GNT_LDR so the CPU wins the first contest.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   req[1:0]    - request vector (bit 0 = CPU, bit 1 = loader)
//   take        - the sequencer consumed the current grant this cycle
//   gnt         - granted port index (combinational from req/last_grant)
// -----------------------------------------------------------------------------
module mem_rr_arb2
    import onchip_mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);

    logic last_grant;

    always_comb begin
        // NOTE: a default is assigned before any branch so no path through
        // this block can leave gnt unassigned and infer a latch.
        gnt = GNT_CPU;
        if (req == 2'b11) begin
            gnt = ~last_grant;
        end else if (req[1]) begin
            gnt = GNT_LDR;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (reset) begin
            last_grant <= GNT_LDR;
        end else if (take && (req == 2'b11)) begin
            last_grant <= gnt;
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port on-chip memory (32-bit words, 1-cycle synchronous
// read, writes gated by debugaccess) between the CPU (port 0) and the
// firmware loader / debug master (port 1), both using the picorv32 native
// valid/ready handshake. Every access takes exactly three cycles:
//   IDLE  : pick a port, latch its request, range-check, load mem_* regs
//   ISSUE : mem_* registers present the access to the memory
//   RESP  : ready pulses on the granted port with rdata (and err_oob)
// All mem_* outputs are registers loaded in IDLE, so there is no
// combinational path from valid to the memory.
//
// Optional build macro MEM_ARB_WR_PROTECT_EN: CPU writes are suppressed
// (nothing reaches the memory), still complete with cpu_ready, and flag
// err_oob. Loader writes are unaffected. Undefined: CPU and loader writes
// behave identically.
//
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   cpu_valid/addr/wdata/wstrb - CPU request (wstrb == 0 means read)
//   cpu_ready, cpu_rdata       - CPU completion pulse and read data
//   ldr_*                      - same as cpu_* for the loader
//   mem_address ... mem_clken  - memory Avalon slave controls
//   mem_readdata               - memory read data (valid in RESP)
//   err_oob                    - pulse with ready on a rejected access
//   busy                       - high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DEPTH     = 12288,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_valid,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [31:0]       cpu_rdata,

    input  logic              ldr_valid,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    input  logic [3:0]        ldr_wstrb,
    output logic              ldr_ready,
    output logic [31:0]       ldr_rdata,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata,

    output logic              err_oob,
    output logic              busy
);

    // Size of the implemented window in bytes. The offset compare is
    // unsigned, so addresses below BASE_ADDR wrap to huge offsets and fail.
    localparam logic [31:0] RANGE_BYTES = 32'(DEPTH) << 2;

    state_e      state;
    logic        gnt;
    logic        take;
    logic        gnt_q;
    logic        rd_ok_q;
    logic        err_q;
    logic [31:0] cpu_rdata_q;
    logic [31:0] ldr_rdata_q;
    logic [31:0] resp_data;

    mem_req_t    sel_req;
    logic [31:0] sel_offset;
    logic        sel_in_range;
    logic        sel_is_write;
    logic        sel_blocked;
    logic        sel_ok;

    assign take = (state == IDLE) && (cpu_valid || ldr_valid);

    mem_rr_arb2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({ldr_valid, cpu_valid}),
        .take  (take),
        .gnt   (gnt)
    );

    always_comb begin
        sel_req = '{addr: cpu_addr, wdata: cpu_wdata, wstrb: cpu_wstrb};
        if (gnt == GNT_LDR) begin
            sel_req = '{addr: ldr_addr, wdata: ldr_wdata, wstrb: ldr_wstrb};
        end
    end

    assign sel_offset   = sel_req.addr - BASE_ADDR;
    assign sel_in_range = sel_offset < RANGE_BYTES;
    assign sel_is_write = |sel_req.wstrb;

`ifdef MEM_ARB_WR_PROTECT_EN
    assign sel_blocked = (gnt == GNT_CPU) && sel_is_write;
`else
    assign sel_blocked = 1'b0;
`endif

    // A rejected access (out of range or write-protected) still completes
    // with ready, but touches no memory signal and reports err_oob.
    assign sel_ok = sel_in_range && !sel_blocked;

    // Read data arrives from the memory in RESP, one cycle after the address
    // was registered, so the response word is muxed straight through while
    // ready is high and the per-port register holds it afterwards.
    assign resp_data = rd_ok_q ? mem_readdata : 32'h0;
    assign cpu_rdata = cpu_ready ? resp_data : cpu_rdata_q;
    assign ldr_rdata = ldr_ready ? resp_data : ldr_rdata_q;

    assign mem_clken = 1'b1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            gnt_q           <= GNT_CPU;
            rd_ok_q         <= 1'b0;
            err_q           <= 1'b0;
            cpu_ready       <= 1'b0;
            ldr_ready       <= 1'b0;
            err_oob         <= 1'b0;
            cpu_rdata_q     <= 32'h0;
            ldr_rdata_q     <= 32'h0;
            mem_address     <= '0;
            mem_byteenable  <= 4'h0;
            mem_chipselect  <= 1'b0;
            mem_write       <= 1'b0;
            mem_debugaccess <= 1'b0;
            mem_writedata   <= 32'h0;
        end else begin
            // Strobes are single-cycle; only the branch below re-asserts them.
            cpu_ready       <= 1'b0;
            ldr_ready       <= 1'b0;
            err_oob         <= 1'b0;
            mem_address     <= '0;
            mem_byteenable  <= 4'h0;
            mem_chipselect  <= 1'b0;
            mem_write       <= 1'b0;
            mem_debugaccess <= 1'b0;
            mem_writedata   <= 32'h0;

            case (state)
                IDLE: begin
                    if (take) begin
                        state   <= ISSUE;
                        gnt_q   <= gnt;
                        rd_ok_q <= sel_ok && !sel_is_write;
                        err_q   <= !sel_ok;
                        if (sel_ok) begin
                            mem_chipselect  <= 1'b1;
                            mem_address     <= sel_offset[ADDR_W+1:2];
                            mem_byteenable  <= sel_is_write ? sel_req.wstrb : 4'hF;
                            mem_write       <= sel_is_write;
                            mem_debugaccess <= sel_is_write;
                            mem_writedata   <= sel_is_write ? sel_req.wdata : 32'h0;
                        end
                    end
                end
                ISSUE: begin
                    state     <= RESP;
                    cpu_ready <= (gnt_q == GNT_CPU);
                    ldr_ready <= (gnt_q == GNT_LDR);
                    err_oob   <= err_q;
                end
                RESP: begin
                    state <= IDLE;
                    if (cpu_ready) begin
                        cpu_rdata_q <= resp_data;
                    end
                    if (ldr_ready) begin
                        ldr_rdata_q <= resp_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Self-checking bench for onchip_mem_arbiter. A behavioural memory drives
// mem_readdata; a transaction-level reference model (word array, round-robin
// winner rule, range/protect rules) predicts every observable value.
// Honours MEM_ARB_WR_PROTECT_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DEPTH     = 12288;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;
    localparam logic [31:0] LIMIT     = 32'(DEPTH) * 32'd4;
`ifdef MEM_ARB_WR_PROTECT_EN
    localparam bit WR_PROTECT = 1'b1;
`else
    localparam bit WR_PROTECT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_valid, ldr_valid;
    logic [31:0]       cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [3:0]        cpu_wstrb, ldr_wstrb;
    logic              cpu_ready, ldr_ready;
    logic [31:0]       cpu_rdata, ldr_rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_debugaccess, mem_clken;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              err_oob, busy;

    int          n_checks = 0;
    int          n_err    = 0;
    int unsigned cyc      = 0;
    int unsigned last_ready_cyc;
    bit          model_last;
    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] env_mem [0:DEPTH-1];
    bit          env_init_done = 1'b0;

    onchip_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_valid       (cpu_valid),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_wstrb       (cpu_wstrb),
        .cpu_ready       (cpu_ready),
        .cpu_rdata       (cpu_rdata),
        .ldr_valid       (ldr_valid),
        .ldr_addr        (ldr_addr),
        .ldr_wdata       (ldr_wdata),
        .ldr_wstrb       (ldr_wstrb),
        .ldr_ready       (ldr_ready),
        .ldr_rdata       (ldr_rdata),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_debugaccess (mem_debugaccess),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata),
        .err_oob         (err_oob),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural altsyncram: synchronous read, write only with debugaccess.
    always @(posedge clk) begin
        if (!env_init_done) begin
            for (int i = 0; i < DEPTH; i++) env_mem[i] <= init_word(i);
            env_init_done <= 1'b1;
        end else if (mem_chipselect && mem_write && mem_debugaccess && (mem_address < DEPTH)) begin
            env_mem[mem_address] <= merge(env_mem[mem_address], mem_writedata, mem_byteenable);
        end
        mem_readdata <= (mem_address < DEPTH) ? env_mem[mem_address] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic v, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws);
        if (p) begin
            ldr_valid = v; ldr_addr = a; ldr_wdata = wd; ldr_wstrb = ws;
        end else begin
            cpu_valid = v; cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws;
        end
    endtask

    // Round-robin rule: a lone requester wins; on a tie the port that did
    // not win the previous tie wins.
    function automatic bit pick(input bit c, input bit l);
        bit w;
        if (c && l) begin
            w = !model_last;
            model_last = w;
        end else begin
            w = l;
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 8)
            0:       return LIMIT + ($urandom % 32'h0100_0000);
            1:       return $urandom_range(0, 63);
            default: return $urandom_range(0, LIMIT - 1);
        endcase
    endfunction

    // Runs one access for port p, starting in an IDLE cycle with p's request
    // already driven. Ends in the following IDLE cycle.
    task automatic serve_one(input bit p, input bit hold, input bit early);
        logic [31:0] a, wd, off, exp_rd;
        logic [3:0]  ws, exp_be;
        bit          wr, ok;
        int unsigned word;
        a  = p ? ldr_addr  : cpu_addr;
        wd = p ? ldr_wdata : cpu_wdata;
        ws = p ? ldr_wstrb : cpu_wstrb;
        off  = a - BASE_ADDR;
        wr   = (ws != 4'h0);
        ok   = (off < LIMIT) && !(WR_PROTECT && !p && wr);
        word = off >> 2;
        exp_be = !ok ? 4'h0 : (wr ? ws : 4'hF);
        exp_rd = (ok && !wr) ? ref_mem[word] : 32'h0;

        step();  // ISSUE
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_cs", 32'(mem_chipselect), 32'(ok));
        check("issue_addr", 32'(mem_address), ok ? word : 32'h0);
        check("issue_we", 32'(mem_write), 32'(ok && wr));
        check("issue_dbg", 32'(mem_debugaccess), 32'(ok && wr));
        check("issue_be", 32'(mem_byteenable), 32'(exp_be));
        check("issue_wdata", mem_writedata, (ok && wr) ? wd : 32'h0);
        check("issue_no_ready", 32'({ldr_ready, cpu_ready}), 32'd0);
        if (early) drive(p, $urandom % 2, $urandom, $urandom, 4'($urandom));

        step();  // RESP
        last_ready_cyc = cyc;
        check("resp_cpu_ready", 32'(cpu_ready), 32'(!p));
        check("resp_ldr_ready", 32'(ldr_ready), 32'(p));
        check("resp_rdata", p ? ldr_rdata : cpu_rdata, exp_rd);
        check("resp_err", 32'(err_oob), 32'(!ok));
        check("resp_cs_idle", 32'(mem_chipselect), 32'd0);
        if (ok && wr) ref_mem[word] = merge(ref_mem[word], wd, ws);
        if (!hold || early) drive(p, 1'b0, $urandom, $urandom, 4'($urandom));

        step();  // IDLE
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ready", 32'({ldr_ready, cpu_ready, err_oob}), 32'd0);
        check("idle_rdata_hold", p ? ldr_rdata : cpu_rdata, exp_rd);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (n) step();
        reset = 1'b0;
        model_last = 1'b1;
    endtask

    initial begin
        bit          p, c_pend, l_pend;
        int unsigned t0;
        logic [31:0] wval;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        do_reset(3);

        // Reset state: everything low except the memory clock enable.
        check("rst_ready", 32'({ldr_ready, cpu_ready}), 32'd0);
        check("rst_rdata", cpu_rdata | ldr_rdata, 32'h0);
        check("rst_mem", 32'({mem_chipselect, mem_write, mem_debugaccess, mem_byteenable}), 32'd0);
        check("rst_maddr", 32'(mem_address) | mem_writedata, 32'h0);
        check("rst_clken", 32'(mem_clken), 32'd1);
        check("rst_misc", 32'({err_oob, busy}), 32'd0);

        // Preload word 1 and word 4 through the loader.
        drive(1, 1'b1, 32'h4, 32'h1234_5678, 4'hF);
        serve_one(1, 0, 0);
        drive(1, 1'b1, 32'h10, 32'h1111_1111, 4'hF);
        serve_one(1, 0, 0);

        // CPU read of word 1 straight after reset: 3-cycle latency.
        do_reset(2);
        t0 = cyc;
        drive(0, 1'b1, 32'h4, 32'h0, 4'h0);
        serve_one(0, 0, 0);
        check("rd_w1_latency", last_ready_cyc - t0, 32'd2);
        check("rd_w1_value", cpu_rdata, 32'h1234_5678);

        // Loader partial write then CPU readback.
        drive(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b0011);
        serve_one(1, 0, 0);
        drive(0, 1'b1, 32'h10, 32'h0, 4'h0);
        serve_one(0, 0, 0);
        check("rd_merge_value", cpu_rdata, 32'h1111_BEEF);

        // Both ports held from reset: CPU, LDR, CPU, LDR; ready at 2,5,8,11.
        do_reset(2);
        t0 = cyc;
        drive(0, 1'b1, 32'h4, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            p = pick(1'b1, 1'b1);
            check("rr_order", 32'(p), 32'(k % 2));
            serve_one(p, 1, 0);
            check("rr_ready_cycle", last_ready_cyc - t0, 32'(2 + 3 * k));
        end
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);

        // Range boundary: last word in range, first word out of range.
        drive(1, 1'b1, LIMIT - 4, 32'h0, 4'h0);
        serve_one(1, 0, 0);
        drive(0, 1'b1, 32'h0000_C000, 32'h0, 4'h0);
        serve_one(0, 0, 0);
        check("oob_rdata_zero", cpu_rdata, 32'h0);
        drive(1, 1'b1, 32'hFFFF_FFF0, 32'hAAAA_5555, 4'hF);
        serve_one(1, 0, 0);

        // Valid dropped and payload scrambled while the access is in flight.
        drive(0, 1'b1, 32'h4, 32'h0, 4'h0);
        serve_one(0, 0, 1);
        check("early_drop_value", cpu_rdata, 32'h1234_5678);

        // CPU write to 0x20, then read back.
        drive(0, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
        serve_one(0, 0, 0);
        drive(0, 1'b1, 32'h20, 32'h0, 4'h0);
        serve_one(0, 0, 0);
        wval = WR_PROTECT ? init_word(8) : 32'hCAFE_F00D;
        check("wr_protect_readback", cpu_rdata, wval);

        // Reset during ISSUE of a CPU write: aborted, no ready.
        drive(0, 1'b1, 32'h30, 32'h7777_8888, 4'hF);
        step();
        check("abort_issue_we", 32'(mem_write), 32'(!WR_PROTECT));
        // The memory already sees this write on the reset edge.
        if (!WR_PROTECT) ref_mem[12] = 32'h7777_8888;
        reset = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        check("abort_we", 32'(mem_write), 32'd0);
        check("abort_cs", 32'(mem_chipselect), 32'd0);
        check("abort_ready", 32'(cpu_ready), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        model_last = 1'b1;
        step();
        check("abort_no_late_ready", 32'({cpu_ready, busy}), 32'd0);

        // Randomised traffic against the reference model.
        for (int it = 0; it < 250; it++) begin
            c_pend = 1'($urandom % 2);
            l_pend = 1'($urandom % 2);
            if (!c_pend && !l_pend) c_pend = 1'b1;
            if (c_pend) drive(0, 1'b1, rand_addr(), $urandom, ($urandom % 2) ? 4'($urandom) : 4'h0);
            if (l_pend) drive(1, 1'b1, rand_addr(), $urandom, ($urandom % 2) ? 4'($urandom) : 4'h0);
            while (c_pend || l_pend) begin
                p = pick(c_pend, l_pend);
                serve_one(p, 0, ($urandom % 4) == 0);
                if (p) l_pend = 1'b0;
                else   c_pend = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares the single-port on-chip program/data memory (altsyncram, 32-bit words, 1-cycle synchronous read, write gated by debugaccess) between two picorv32-native-interface requesters.
- Port 0 is the CPU; port 1 is the firmware loader/debug master.
- Sits between the CPU bus decoder and the memory's Avalon slave. Handles arbitration, address range checks, write gating and read-latency sequencing.

Parameters:
- ADDR_W, 14, memory word-address width.
- DEPTH, 12288, number of 32-bit words implemented.
- BASE_ADDR, 32'h0000_0000, byte address that maps to memory word 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU request.
- cpu_addr  in  32  CPU byte address.
- cpu_wdata  in  32  CPU write data.
- cpu_wstrb  in  4  CPU byte strobes; 0 means read.
- cpu_ready  out  1  one-cycle completion pulse to CPU.
- cpu_rdata  out  32  CPU read data, valid with cpu_ready.
- ldr_valid, ldr_addr, ldr_wdata, ldr_wstrb, ldr_ready, ldr_rdata: same widths and meanings as the cpu_* ports, for the loader.
- mem_address  out  ADDR_W  memory word address.
- mem_byteenable  out  4  memory byte enables.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write.
- mem_debugaccess  out  1  memory write permission.
- mem_writedata  out  32  memory write data.
- mem_clken  out  1  memory clock enable; constant 1.
- mem_readdata  in  32  memory read data.
- err_oob  out  1  one-cycle pulse on an out-of-range access.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, active-high): all outputs 0 except mem_clken=1. State=IDLE. last_grant=1, so the CPU wins the first contest.
- FSM IDLE -> ISSUE -> RESP -> IDLE. Every access, read or write, takes exactly 3 cycles from valid sampled in IDLE to the ready pulse.
- IDLE:
  - Sample both valids. With a single requester, grant it.
  - With both requesting, grant the port != last_grant (round-robin), then update last_grant.
  - Latch the granted request: offset = addr - BASE_ADDR; in_range = offset < DEPTH*4. The unsigned compare treats addresses below BASE_ADDR as out of range.
  - Go to ISSUE.
- ISSUE, in range: drive mem_chipselect=1 and mem_address=offset[ADDR_W+1:2]; addr[1:0] is ignored.
  - Read: mem_byteenable=4'hF, mem_write=0.
  - Write: mem_write=1, mem_byteenable=wstrb, mem_debugaccess=1, mem_writedata=wdata.
- ISSUE, out of range: no memory signals asserted.
- RESP: pulse the granted port's ready for 1 cycle.
  - rdata = mem_readdata for an in-range read; 0 otherwise.
  - err_oob pulses in the same cycle for an out-of-range access.
  - The other port's ready stays 0.
- rdata is held between transactions (register). It is meaningful only while ready=1.
- Requesters must hold valid and payload until ready, then deassert valid for at least the IDLE sample (picorv32 behaviour).
  - The payload is latched in IDLE; later changes are ignored.
  - If valid drops mid-transaction, the access still completes and ready still pulses.
- A requester holding valid continuously gets at most every other grant while the other port is also requesting. Neither port can starve.
- Reset asserted in ISSUE or RESP: the next cycle is IDLE with all strobes 0. No partial write is issued after the reset edge; the aborted request gets no ready.
- Memory signals are registered outputs: no combinational path from valid to mem_*.

Optional Feature:
- MEM_ARB_WR_PROTECT_EN defined:
  - CPU writes are suppressed: ISSUE asserts no mem signals.
  - cpu_ready still pulses in RESP, and err_oob pulses to flag the violation.
  - Loader writes are unaffected.
- Not defined: CPU writes behave exactly as loader writes.

Decomposition:
- Package onchip_mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, RESP};
  - grant encoding constants GNT_CPU=0 and GNT_LDR=1;
  - a request struct {addr, wdata, wstrb}.
- One sub-module, mem_rr_arb2: the 2-way round-robin picker with the last_grant register. Inputs req[1:0] and a take strobe; output gnt index.

Test Plan:
- CPU read at 0x0000_0004 with memory word 1 = 0x1234_5678: cpu_valid cycle 0 -> mem_chipselect=1, mem_address=1 in cycle 1 -> cpu_ready=1, cpu_rdata=0x1234_5678 in cycle 2.
- Loader write 0xDEAD_BEEF to 0x10 with wstrb=4'b0011, then CPU read of 0x10 (old word 0x1111_1111) -> mem_write=1, mem_debugaccess=1, mem_byteenable=4'b0011 -> readback 0x1111_BEEF.
- Both valid held for 4 accesses from reset -> grant order CPU, LDR, CPU, LDR; ready pulses at cycles 2, 5, 8, 11.
- CPU read at 0x0000_C000 (word 12288) -> no mem_chipselect; cpu_ready with rdata=0 and err_oob=1 at cycle 2.
- CPU write in flight, reset asserted during ISSUE -> mem_write=0 on the following cycle; no cpu_ready; busy=0.
- With MEM_ARB_WR_PROTECT_EN: CPU write to 0x20 -> mem_write stays 0, cpu_ready and err_oob pulse, and a later read returns the unchanged word.
